// File: rtl/cache_victim_buffer_pkg.sv
// Shared definitions for the cache eviction path: victim-buffer FSM states
// and the line-offset width helper.
package cache_victim_buffer_pkg;

  typedef enum logic [1:0] {
    VB_IDLE = 2'd0,
    VB_REQ  = 2'd1,
    VB_DATA = 2'd2,
    VB_RESP = 2'd3
  } vb_state_e;

  function automatic int vb_offset_bits(input int line_words, input int data_width);
    return $clog2(line_words * data_width / 8);
  endfunction

endpackage

// File: rtl/cache_victim_buffer.sv
// Single-entry write-back victim buffer: drains dirty evicted lines to memory
// as an address request plus word burst and flags lookups hitting the held line.
//
// state   | meaning
// IDLE    | empty, accepting victims
// REQ     | write-address request outstanding
// DATA    | streaming line words
// RESP    | waiting for write completion
module cache_victim_buffer
  import cache_victim_buffer_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_WAY    = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             evict_valid,
  output logic                             evict_ready,
  input  logic                             evict_dirty,
  input  logic [NUM_WAY-1:0]               evict_way,
  input  logic [ADDR_WIDTH-1:0]            evict_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] evict_data,
  output logic [NUM_WAY-1:0]               busy_way,
  output logic                             wr_req,
  input  logic                             wr_ack,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic                             wr_data_valid,
  input  logic                             wr_data_ready,
  output logic [DATA_WIDTH-1:0]            wr_data,
  output logic                             wr_last,
  input  logic                             wr_done,
  input  logic [ADDR_WIDTH-1:0]            lookup_addr,
  output logic                             lookup_hit
);

  localparam int OFFSET_BITS = vb_offset_bits(LINE_WORDS, DATA_WIDTH);
  localparam int CNT_W       = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};

  vb_state_e                        state_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [LINE_WORDS*DATA_WIDTH-1:0] line_q;
  logic [ADDR_WIDTH-1:0]            addr_q;
  logic [NUM_WAY-1:0]               busy_way_q;
  logic                             evict_ready_q;
  logic                             wr_req_q;
  logic                             wr_data_valid_q;
  logic [DATA_WIDTH-1:0]            word_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= VB_IDLE;
      cnt_q           <= '0;
      line_q          <= '0;
      addr_q          <= '0;
      busy_way_q      <= '0;
      evict_ready_q   <= 1'b1;
      wr_req_q        <= 1'b0;
      wr_data_valid_q <= 1'b0;
    end else begin
      case (state_q)
        VB_IDLE: begin
          // Clean victims are simply dropped; only dirty ones occupy the buffer.
          if (evict_valid && evict_dirty) begin
            state_q       <= VB_REQ;
            line_q        <= evict_data;
            addr_q        <= evict_addr & ~OFFSET_MASK;
            busy_way_q    <= evict_way;
            evict_ready_q <= 1'b0;
            wr_req_q      <= 1'b1;
          end
        end
        VB_REQ: begin
          if (wr_ack) begin
            state_q         <= VB_DATA;
            cnt_q           <= '0;
            wr_req_q        <= 1'b0;
            wr_data_valid_q <= 1'b1;
          end
        end
        VB_DATA: begin
          if (wr_data_ready) begin
            if (cnt_q == LAST_IDX) begin
              state_q         <= VB_RESP;
              wr_data_valid_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        VB_RESP: begin
          if (wr_done) begin
            state_q       <= VB_IDLE;
            busy_way_q    <= '0;
            evict_ready_q <= 1'b1;
          end
        end
        default: state_q <= VB_IDLE;
      endcase
    end
  end

  assign word_d = line_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];

  assign evict_ready   = evict_ready_q;
  assign busy_way      = busy_way_q;
  assign wr_req        = wr_req_q;
  assign wr_addr       = addr_q;
  assign wr_data_valid = wr_data_valid_q;
  assign wr_data       = (state_q == VB_DATA) ? word_d : '0;
  assign wr_last       = (state_q == VB_DATA) && (cnt_q == LAST_IDX);
  assign lookup_hit    = (state_q != VB_IDLE) && ((lookup_addr & ~OFFSET_MASK) == addr_q);

endmodule

// File: tb/tb_cache_victim_buffer.sv
// Self-checking bench for cache_victim_buffer: directed vector table, hand-written
// stall/reset sequences, and randomized traffic against a transaction-level model.
module tb_cache_victim_buffer;

  localparam int LW = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              evict_valid, evict_ready, evict_dirty;
  logic [NW-1:0]     evict_way, busy_way;
  logic [AW-1:0]     evict_addr, wr_addr, lookup_addr;
  logic [LW*DW-1:0]  evict_data;
  logic              wr_req, wr_ack, wr_data_valid, wr_data_ready, wr_last, wr_done, lookup_hit;
  logic [DW-1:0]     wr_data;

  always #5 clk = ~clk;

  cache_victim_buffer #(.LINE_WORDS(LW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WAY(NW)) dut (
    .clk(clk), .reset(reset),
    .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_dirty(evict_dirty),
    .evict_way(evict_way), .evict_addr(evict_addr), .evict_data(evict_data),
    .busy_way(busy_way),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .wr_last(wr_last), .wr_done(wr_done),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ev_valid, ev_dirty, ack, dready, done;
    logic [31:0] lk;
    logic        e_ready, e_req, e_dv, e_last;
    logic [31:0] e_data, e_addr;
    logic [1:0]  e_bway;
    logic        e_hit;
  } vec_t;

  vec_t tbl[10];

  // Transaction-level reference state
  bit          m_busy;
  bit          m_acked;
  int          m_sent;
  logic [31:0] m_addr, m_wr_addr;
  logic [1:0]  m_way;
  logic [31:0] m_words[LW];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a_base;
    logic        pat[4];
    int          reqcnt, hs;

    reset = 1'b1; evict_valid = 0; evict_dirty = 0; evict_way = '0; evict_addr = '0;
    evict_data = '0; wr_ack = 0; wr_data_ready = 0; wr_done = 0; lookup_addr = '0;

    // Reset values
    step(); step();
    chk("rst_ready", evict_ready, 1);
    chk("rst_req", wr_req, 0);
    chk("rst_dv", wr_data_valid, 0);
    chk("rst_last", wr_last, 0);
    chk("rst_hit", lookup_hit, 0);
    chk("rst_bway", busy_way, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);

    // Directed table: clean evict, then dirty evict at 0x1000_0014 with memory always ready
    a_base = 32'h1000_0010;
    tbl[0] = '{1,0,1,1,0, 32'h1000_0014, 1,0,0,0, 32'h0, 32'h0, 2'b00, 0};
    tbl[1] = '{0,0,1,1,1, 32'h1000_0014, 1,0,0,0, 32'h0, 32'h0, 2'b00, 0};
    tbl[2] = '{1,1,1,1,0, 32'h1000_0014, 1,0,0,0, 32'h0, 32'h0, 2'b00, 0};
    tbl[3] = '{0,0,1,1,0, 32'h1000_001C, 0,1,0,0, 32'h0, a_base, 2'b10, 1};
    tbl[4] = '{0,0,1,1,0, 32'h1000_0020, 0,0,1,0, 32'hA000_0000, a_base, 2'b10, 0};
    tbl[5] = '{0,0,1,1,1, 32'h1000_001C, 0,0,1,0, 32'hA000_0001, a_base, 2'b10, 1};
    tbl[6] = '{0,0,1,1,0, 32'h1000_0010, 0,0,1,0, 32'hA000_0002, a_base, 2'b10, 1};
    tbl[7] = '{0,0,1,1,0, 32'h1000_001F, 0,0,1,1, 32'hA000_0003, a_base, 2'b10, 1};
    tbl[8] = '{1,1,1,1,1, 32'h1000_0010, 0,0,0,0, 32'h0, a_base, 2'b10, 1};
    tbl[9] = '{0,0,1,1,0, 32'h1000_0010, 1,0,0,0, 32'h0, a_base, 2'b00, 0};

    step();
    reset = 1'b0;
    evict_way  = 2'b10;
    evict_addr = 32'h1000_0014;
    evict_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    for (int r = 0; r < 10; r++) begin
      evict_valid = tbl[r].ev_valid; evict_dirty = tbl[r].ev_dirty;
      wr_ack = tbl[r].ack; wr_data_ready = tbl[r].dready; wr_done = tbl[r].done;
      lookup_addr = tbl[r].lk;
      #1;
      chk($sformatf("tbl%0d_ready", r), evict_ready, tbl[r].e_ready);
      chk($sformatf("tbl%0d_req", r), wr_req, tbl[r].e_req);
      chk($sformatf("tbl%0d_dv", r), wr_data_valid, tbl[r].e_dv);
      chk($sformatf("tbl%0d_last", r), wr_last, tbl[r].e_last);
      chk($sformatf("tbl%0d_bway", r), busy_way, tbl[r].e_bway);
      chk($sformatf("tbl%0d_hit", r), lookup_hit, tbl[r].e_hit);
      if (r >= 3) chk($sformatf("tbl%0d_addr", r), wr_addr, tbl[r].e_addr);
      if (tbl[r].e_dv) chk($sformatf("tbl%0d_data", r), wr_data, tbl[r].e_data);
      step();
    end

    // Delayed ack (3 cycles) and data-ready pattern 1,0,0,1
    evict_valid = 1; evict_dirty = 1; evict_way = 2'b01; evict_addr = 32'h2000_0040;
    evict_data = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    wr_ack = 0; wr_data_ready = 0; wr_done = 0;
    #1;
    chk("stall_accept_ready", evict_ready, 1);
    step();
    evict_valid = 0;
    reqcnt = 0;
    for (int k = 0; k < 4; k++) begin
      wr_ack = (k == 3);
      #1;
      if (wr_req) reqcnt++;
      step();
    end
    wr_ack = 0;
    chk("stall_req_cycles", reqcnt, 4);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    hs = 0;
    for (int c = 0; c < 16 && hs < LW; c++) begin
      wr_data_ready = pat[c % 4];
      #1;
      if (!wr_data_valid) chk("stall_dv", wr_data_valid, 1);
      else begin
        chk("stall_data", wr_data, 32'hB000_0000 + hs);
        chk("stall_last", wr_last, (hs == LW - 1));
      end
      if (wr_data_valid && wr_data_ready) hs++;
      step();
    end
    chk("stall_handshakes", hs, LW);
    wr_data_ready = 0;
    #1;
    chk("stall_resp_dv", wr_data_valid, 0);
    chk("stall_resp_ready", evict_ready, 0);
    wr_done = 1;
    step();
    wr_done = 0;
    chk("stall_back_ready", evict_ready, 1);
    chk("stall_back_bway", busy_way, 0);

    // Reset asserted after word 1 of a burst
    evict_valid = 1; evict_dirty = 1; evict_way = 2'b10; evict_addr = 32'h3000_0000;
    evict_data = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
    wr_ack = 1; wr_data_ready = 1; lookup_addr = 32'h3000_0004;
    step();
    evict_valid = 0;
    step();
    chk("midrst_w0", wr_data, 32'hC000_0000);
    step();
    chk("midrst_w1", wr_data, 32'hC000_0001);
    step();
    reset = 1;
    step();
    reset = 0; wr_ack = 0; wr_data_ready = 0;
    #1;
    chk("midrst_dv", wr_data_valid, 0);
    chk("midrst_bway", busy_way, 0);
    chk("midrst_ready", evict_ready, 1);
    chk("midrst_req", wr_req, 0);
    chk("midrst_hit", lookup_hit, 0);

    // Randomized traffic against the transaction model
    m_busy = 0; m_acked = 0; m_sent = 0; m_addr = '0; m_wr_addr = '0; m_way = '0;
    for (int i = 0; i < 3000; i++) begin
      bit          rst, waiting;
      logic [31:0] w[LW];
      bit          e_dv;
      step();
      rst = (i == 0) || ($urandom_range(0, 299) == 0);
      reset = rst;
      evict_valid = ($urandom_range(0, 9) < 6);
      evict_dirty = $urandom_range(0, 1);
      evict_way = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      evict_addr = $urandom;
      for (int k = 0; k < LW; k++) w[k] = $urandom;
      evict_data = {w[3], w[2], w[1], w[0]};
      wr_ack = $urandom_range(0, 1);
      wr_data_ready = ($urandom_range(0, 2) != 0);
      waiting = m_busy && m_acked && (m_sent == LW);
      wr_done = waiting ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0:       lookup_addr = m_addr + $urandom_range(0, 15);
        1:       lookup_addr = ($urandom_range(0, 1) != 0) ? m_addr + 16 : m_addr - 1;
        default: lookup_addr = $urandom;
      endcase
      #1;
      e_dv = m_busy && m_acked && (m_sent < LW);
      chk("rnd_ready", evict_ready, !m_busy);
      chk("rnd_req", wr_req, m_busy && !m_acked);
      chk("rnd_dv", wr_data_valid, e_dv);
      chk("rnd_last", wr_last, e_dv && (m_sent == LW - 1));
      chk("rnd_bway", busy_way, m_busy ? m_way : 2'b00);
      chk("rnd_addr", wr_addr, m_wr_addr);
      chk("rnd_hit", lookup_hit, m_busy && ((lookup_addr / 16) == (m_addr / 16)));
      if (e_dv) chk("rnd_data", wr_data, m_words[m_sent]);

      if (rst) begin
        m_busy = 0; m_acked = 0; m_sent = 0; m_addr = '0; m_wr_addr = '0; m_way = '0;
      end else if (!m_busy) begin
        if (evict_valid && evict_dirty) begin
          m_busy = 1; m_acked = 0; m_sent = 0; m_way = evict_way;
          m_addr = (evict_addr / 16) * 16;
          m_wr_addr = m_addr;
          for (int k = 0; k < LW; k++) m_words[k] = w[k];
        end
      end else if (!m_acked) begin
        if (wr_ack) m_acked = 1;
      end else if (m_sent < LW) begin
        if (wr_data_ready) m_sent++;
      end else if (wr_done) begin
        m_busy = 0;
      end
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
